// File: rtl/chacha_block_core.sv
// rtl/chacha_block_core.sv - sequential ChaCha20 block function over a bank of quarter-round lanes (optional CHACHA_XOR_EN)

module chacha_qr_lane (
    input  logic [31:0] a_i,
    input  logic [31:0] b_i,
    input  logic [31:0] c_i,
    input  logic [31:0] d_i,
    output logic [31:0] a_o,
    output logic [31:0] b_o,
    output logic [31:0] c_o,
    output logic [31:0] d_o
);
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] c;
    logic [31:0] d;

    // One full quarter round; rotations are plain rewiring.
    always_comb begin
        a = a_i;
        b = b_i;
        c = c_i;
        d = d_i;
        a = a + b;
        d = d ^ a;
        d = {d[15:0], d[31:16]};
        c = c + d;
        b = b ^ c;
        b = {b[19:0], b[31:20]};
        a = a + b;
        d = d ^ a;
        d = {d[23:0], d[31:24]};
        c = c + d;
        b = b ^ c;
        b = {b[24:0], b[31:25]};
        a_o = a;
        b_o = b;
        c_o = c;
        d_o = d;
    end
endmodule

module chacha_block_core #(
    parameter int ROUNDS   = 20,
    parameter int QR_LANES = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [255:0] key,
    input  logic [95:0]  nonce,
    input  logic [31:0]  counter,
`ifdef CHACHA_XOR_EN
    input  logic [511:0] data_in,
`endif
    output logic         out_valid,
    input  logic         out_ready,
    output logic [511:0] out_block,
    output logic         busy
);
    // Lane groups per half-round; each step covers one group.
    localparam int GROUPS = (QR_LANES > 0) ? 4 / QR_LANES : 1;
    localparam int STEPS  = ROUNDS * GROUPS;
    localparam int STEP_W = (STEPS > 2) ? $clog2(STEPS) : 1;

    if ((ROUNDS < 2) || ((ROUNDS % 2) != 0)) begin : g_bad_rounds
        $error("chacha_block_core: ROUNDS must be even and >= 2");
    end
    if (!((QR_LANES == 1) || (QR_LANES == 2) || (QR_LANES == 4))) begin : g_bad_lanes
        $error("chacha_block_core: QR_LANES must be 1, 2 or 4");
    end

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_ADD, S_DONE} state_t;
    typedef logic [15:0][31:0] words_t;

    state_t            state_q;
    state_t            state_d;
    logic [STEP_W-1:0] step_q;
    logic [STEP_W-1:0] step_d;
    words_t            working_q;
    words_t            working_d;
    words_t            saved_q;
    words_t            saved_d;
    logic [511:0]      out_block_q;
    logic [511:0]      out_block_d;
    logic              out_valid_q;
    logic              out_valid_d;
`ifdef CHACHA_XOR_EN
    logic [511:0]      data_q;
    logic [511:0]      data_d;
`endif

    words_t            init_state;
    words_t            round_state;
    words_t            final_sum;

    logic [3:0]        idx_a [QR_LANES];
    logic [3:0]        idx_b [QR_LANES];
    logic [3:0]        idx_c [QR_LANES];
    logic [3:0]        idx_d [QR_LANES];
    logic [31:0]       lane_a_in  [QR_LANES];
    logic [31:0]       lane_b_in  [QR_LANES];
    logic [31:0]       lane_c_in  [QR_LANES];
    logic [31:0]       lane_d_in  [QR_LANES];
    logic [31:0]       lane_a_out [QR_LANES];
    logic [31:0]       lane_b_out [QR_LANES];
    logic [31:0]       lane_c_out [QR_LANES];
    logic [31:0]       lane_d_out [QR_LANES];

    // Initial state: constants, key, counter, nonce.
    always_comb begin
        init_state     = '0;
        init_state[0]  = 32'h61707865;
        init_state[1]  = 32'h3320646e;
        init_state[2]  = 32'h79622d32;
        init_state[3]  = 32'h6b206574;
        for (int i = 0; i < 8; i++) begin
            init_state[4 + i] = key[32*i +: 32];
        end
        init_state[12] = counter;
        for (int i = 0; i < 3; i++) begin
            init_state[13 + i] = nonce[32*i +: 32];
        end
    end

    // Pick the word indices for each lane: even half-rounds are columns, odd are diagonals.
    always_comb begin
        int   grp;
        int   q;
        logic diag;
        grp  = int'(step_q) % GROUPS;
        diag = ((int'(step_q) / GROUPS) % 2) == 1;
        q    = 0;
        for (int l = 0; l < QR_LANES; l++) begin
            q        = grp * QR_LANES + l;
            idx_a[l] = 4'(q);
            idx_b[l] = 4'(4  + (diag ? ((q + 1) % 4) : q));
            idx_c[l] = 4'(8  + (diag ? ((q + 2) % 4) : q));
            idx_d[l] = 4'(12 + (diag ? ((q + 3) % 4) : q));
            lane_a_in[l] = working_q[idx_a[l]];
            lane_b_in[l] = working_q[idx_b[l]];
            lane_c_in[l] = working_q[idx_c[l]];
            lane_d_in[l] = working_q[idx_d[l]];
        end
    end

    for (genvar l = 0; l < QR_LANES; l++) begin : g_lane
        chacha_qr_lane u_lane (
            .a_i (lane_a_in[l]),
            .b_i (lane_b_in[l]),
            .c_i (lane_c_in[l]),
            .d_i (lane_d_in[l]),
            .a_o (lane_a_out[l]),
            .b_o (lane_b_out[l]),
            .c_o (lane_c_out[l]),
            .d_o (lane_d_out[l])
        );
    end

    // Write lane results back; lanes of one group never share a word.
    always_comb begin
        round_state = working_q;
        for (int l = 0; l < QR_LANES; l++) begin
            round_state[idx_a[l]] = lane_a_out[l];
            round_state[idx_b[l]] = lane_b_out[l];
            round_state[idx_c[l]] = lane_c_out[l];
            round_state[idx_d[l]] = lane_d_out[l];
        end
    end

    // Feed-forward: working state plus the saved input state, per word.
    always_comb begin
        final_sum = '0;
        for (int i = 0; i < 16; i++) begin
            final_sum[i] = working_q[i] + saved_q[i];
        end
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (in_valid) state_d = S_RUN;
            S_RUN:   if (step_q == STEP_W'(STEPS - 1)) state_d = S_ADD;
            S_ADD:   state_d = S_DONE;
            S_DONE:  if (out_ready) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Datapath next values: capture on accept, round steps, feed-forward, handshake clear.
    always_comb begin
        step_d      = step_q;
        working_d   = working_q;
        saved_d     = saved_q;
        out_block_d = out_block_q;
        out_valid_d = out_valid_q;
`ifdef CHACHA_XOR_EN
        data_d      = data_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    working_d = init_state;
                    saved_d   = init_state;
                    step_d    = '0;
`ifdef CHACHA_XOR_EN
                    data_d    = data_in;
`endif
                end
            end
            S_RUN: begin
                working_d = round_state;
                step_d    = (step_q == STEP_W'(STEPS - 1)) ? '0 : step_q + 1'b1;
            end
            S_ADD: begin
`ifdef CHACHA_XOR_EN
                out_block_d = final_sum ^ data_q;
`else
                out_block_d = final_sum;
`endif
                out_valid_d = 1'b1;
            end
            S_DONE: begin
                if (out_ready) out_valid_d = 1'b0;
            end
            default: ;
        endcase
    end

    // Datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            step_q      <= '0;
            working_q   <= '0;
            saved_q     <= '0;
            out_block_q <= '0;
            out_valid_q <= 1'b0;
`ifdef CHACHA_XOR_EN
            data_q      <= '0;
`endif
        end else begin
            step_q      <= step_d;
            working_q   <= working_d;
            saved_q     <= saved_d;
            out_block_q <= out_block_d;
            out_valid_q <= out_valid_d;
`ifdef CHACHA_XOR_EN
            data_q      <= data_d;
`endif
        end
    end

    // Outputs decoded from state and registers.
    always_comb begin
        in_ready  = (state_q == S_IDLE);
        busy      = (state_q == S_RUN) || (state_q == S_ADD);
        out_valid = out_valid_q;
        out_block = out_block_q;
    end
endmodule

// File: tb/tb_chacha_block_core.sv
// tb/tb_chacha_block_core.sv - scoreboard bench for chacha_block_core
module tb_chacha_block_core;
    localparam int ROUNDS = 20;
    localparam int STEPS4 = ROUNDS;
    localparam int BUDGET = 300;

    typedef logic [15:0][31:0] st_t;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [255:0] key;
    logic [95:0]  nonce;
    logic [31:0]  counter;
    logic         out_valid;
    logic         out_ready;
    logic [511:0] out_block;
    logic         busy;
    logic         a_valid;
    logic         a1_in_ready, a1_out_valid, a1_busy;
    logic         a2_in_ready, a2_out_valid, a2_busy;
    logic [511:0] a1_block, a2_block;
`ifdef CHACHA_XOR_EN
    logic [511:0] data_in;
`endif

    int           n_vec = 0;
    int           n_bad = 0;
    int           cyc = 0;
    int           acc_cyc = 0;
    int           aux_acc = 0;
    logic         ov_prev = 1'b0;
    logic [511:0] exp_q[$];
    logic [511:0] aq1[$];
    logic [511:0] aq2[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    chacha_block_core #(.ROUNDS(ROUNDS), .QR_LANES(4)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .key(key), .nonce(nonce), .counter(counter),
`ifdef CHACHA_XOR_EN
        .data_in(data_in),
`endif
        .out_valid(out_valid), .out_ready(out_ready), .out_block(out_block), .busy(busy)
    );

    chacha_block_core #(.ROUNDS(ROUNDS), .QR_LANES(1)) dut_l1 (
        .clk(clk), .rst_n(rst_n), .in_valid(a_valid), .in_ready(a1_in_ready),
        .key(key), .nonce(nonce), .counter(counter),
`ifdef CHACHA_XOR_EN
        .data_in(data_in),
`endif
        .out_valid(a1_out_valid), .out_ready(1'b1), .out_block(a1_block), .busy(a1_busy)
    );

    chacha_block_core #(.ROUNDS(ROUNDS), .QR_LANES(2)) dut_l2 (
        .clk(clk), .rst_n(rst_n), .in_valid(a_valid), .in_ready(a2_in_ready),
        .key(key), .nonce(nonce), .counter(counter),
`ifdef CHACHA_XOR_EN
        .data_in(data_in),
`endif
        .out_valid(a2_out_valid), .out_ready(1'b1), .out_block(a2_block), .busy(a2_busy)
    );

    function automatic logic [31:0] rotl(input logic [31:0] x, input int n);
        return (x << n) | (x >> (32 - n));
    endfunction

    function automatic st_t qr(input st_t x, input int a, input int b, input int c, input int d);
        x[a] = x[a] + x[b]; x[d] = rotl(x[d] ^ x[a], 16);
        x[c] = x[c] + x[d]; x[b] = rotl(x[b] ^ x[c], 12);
        x[a] = x[a] + x[b]; x[d] = rotl(x[d] ^ x[a], 8);
        x[c] = x[c] + x[d]; x[b] = rotl(x[b] ^ x[c], 7);
        return x;
    endfunction

    function automatic logic [511:0] model(input logic [255:0] k, input logic [95:0] n, input logic [31:0] c);
        st_t s;
        st_t w;
        s[0] = 32'h61707865; s[1] = 32'h3320646e; s[2] = 32'h79622d32; s[3] = 32'h6b206574;
        for (int i = 0; i < 8; i++) s[4 + i] = k[32*i +: 32];
        s[12] = c;
        for (int i = 0; i < 3; i++) s[13 + i] = n[32*i +: 32];
        w = s;
        for (int r = 0; r < ROUNDS / 2; r++) begin
            w = qr(w, 0, 4, 8, 12); w = qr(w, 1, 5, 9, 13); w = qr(w, 2, 6, 10, 14); w = qr(w, 3, 7, 11, 15);
            w = qr(w, 0, 5, 10, 15); w = qr(w, 1, 6, 11, 12); w = qr(w, 2, 7, 8, 13); w = qr(w, 3, 4, 9, 14);
        end
        for (int i = 0; i < 16; i++) w[i] = w[i] + s[i];
        return w;
    endfunction

    function automatic logic [511:0] expect_blk(input logic [255:0] k, input logic [95:0] n, input logic [31:0] c);
`ifdef CHACHA_XOR_EN
        return model(k, n, c) ^ data_in;
`else
        return model(k, n, c);
`endif
    endfunction

    task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic timeout(input string name);
        n_vec++;
        n_bad++;
        $display("FAIL %s: timed out after %0d cycles", name, BUDGET);
    endtask

    // Called at posedge+1; returns once the accept edge has passed.
    task automatic send(input logic [255:0] k, input logic [95:0] n, input logic [31:0] c, output int acc);
        int t;
        t = 0;
        key = k; nonce = n; counter = c; in_valid = 1'b1;
        @(negedge clk);
        while (!in_ready && t < BUDGET) begin
            t++;
            @(negedge clk);
        end
        acc = cyc + 1;
        if (!in_ready) timeout("send");
        else exp_q.push_back(expect_blk(k, n, c));
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    // Returns at the negedge where out_valid is seen.
    task automatic wait_out(output logic [511:0] blk);
        int t;
        t = 0;
        @(negedge clk);
        while (!out_valid && t < BUDGET) begin
            t++;
            @(negedge clk);
        end
        if (!out_valid) timeout("wait_out");
        blk = out_block;
    endtask

    // Main scoreboard monitor: latency of every block and in-order block compare at handshake.
    always @(negedge clk) begin
        if (!rst_n) begin
            ov_prev = 1'b0;
        end else begin
            if (in_valid && in_ready) acc_cyc = cyc + 1;
            if (out_valid && !ov_prev) chk32("latency_l4", 32'(cyc - acc_cyc), 32'(STEPS4 + 1));
            ov_prev = out_valid;
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    n_vec++;
                    n_bad++;
                    $display("FAIL block_unexpected: got %h want none", out_block);
                end else begin
                    chk("block_l4", out_block, exp_q.pop_front());
                end
            end
        end
    end

    // Monitor for the 1- and 2-lane instances.
    always @(negedge clk) begin
        if (rst_n && a1_out_valid) begin
            chk32("latency_l1", 32'(cyc - aux_acc), 32'(ROUNDS * 4 + 1));
            if (aq1.size() == 0) begin n_vec++; n_bad++; $display("FAIL block_l1_unexpected: got %h want none", a1_block); end
            else chk("block_l1", a1_block, aq1.pop_front());
        end
        if (rst_n && a2_out_valid) begin
            chk32("latency_l2", 32'(cyc - aux_acc), 32'(ROUNDS * 2 + 1));
            if (aq2.size() == 0) begin n_vec++; n_bad++; $display("FAIL block_l2_unexpected: got %h want none", a2_block); end
            else chk("block_l2", a2_block, aq2.pop_front());
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [255:0] rfc_key;
        logic [95:0]  rfc_nonce;
        logic [255:0] bp_key;
        logic [511:0] blk;
        logic [511:0] b0;
        int           acc1;
        int           acc2;
        int           t;
`ifdef CHACHA_XOR_EN
        string        pt_s;
        logic [511:0] pt;
        logic [511:0] ct;
`endif

        for (int i = 0; i < 32; i++) rfc_key[8*i +: 8] = 8'(i);
        rfc_nonce = {32'h00000000, 32'h4a000000, 32'h09000000};
        rst_n = 1'b0; in_valid = 1'b0; a_valid = 1'b0; out_ready = 1'b0;
        key = '0; nonce = '0; counter = '0;
`ifdef CHACHA_XOR_EN
        data_in = '0;
`endif
        repeat (3) @(posedge clk);
        #1;
        chk32("rst_in_ready", 32'(in_ready), 32'd1);
        chk32("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_block", out_block, '0);
        chk32("rst_busy", 32'(busy), 32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // RFC 8439 2.3.2 vector, four lanes.
        out_ready = 1'b1;
        send(rfc_key, rfc_nonce, 32'd1, acc1);
        chk32("run_busy", 32'(busy), 32'd1);
        chk32("run_in_ready", 32'(in_ready), 32'd0);
        wait_out(blk);
        chk32("rfc_w0", blk[31:0], 32'he4e7f110);
        chk32("rfc_w1", blk[63:32], 32'h15593bd1);
        chk32("rfc_w4", blk[159:128], 32'hc7f4d1c7);
        chk32("rfc_w15", blk[511:480], 32'h4e3c50a2);
        @(posedge clk); #1;

        // Same vector through the 1- and 2-lane instances.
        key = rfc_key; nonce = rfc_nonce; counter = 32'd1; a_valid = 1'b1;
        aux_acc = cyc + 1;
        aq1.push_back(expect_blk(rfc_key, rfc_nonce, 32'd1));
        aq2.push_back(expect_blk(rfc_key, rfc_nonce, 32'd1));
        @(posedge clk); #1 a_valid = 1'b0;
        t = 0;
        while ((aq1.size() != 0 || aq2.size() != 0) && t < BUDGET) begin t++; @(negedge clk); end
        if (aq1.size() != 0 || aq2.size() != 0) timeout("aux_lanes");
        @(posedge clk); #1;

        // Backpressure with a second request held during DONE.
        out_ready = 1'b0;
        send(rfc_key, rfc_nonce, 32'd5, acc1);
        wait_out(b0);
        @(posedge clk); #1;
        bp_key = rfc_key ^ {8{32'h11111111}};
        key = bp_key; counter = 32'd6; in_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("bp_hold_block", out_block, b0);
            chk32("bp_in_ready", 32'(in_ready), 32'd0);
            chk32("bp_out_valid", 32'(out_valid), 32'd1);
        end
        @(posedge clk); #1 out_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk32("bp_next_accept", 32'(in_ready), 32'd1);
        if (in_ready) exp_q.push_back(expect_blk(bp_key, rfc_nonce, 32'd6));
        @(posedge clk); #1 in_valid = 1'b0;
        wait_out(blk);
        @(posedge clk); #1;

        // Reset at step 7 of a run.
        send(rfc_key, rfc_nonce, 32'd1, acc1);
        repeat (7) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        chk32("midrst_in_ready", 32'(in_ready), 32'd1);
        chk32("midrst_out_valid", 32'(out_valid), 32'd0);
        chk("midrst_out_block", out_block, '0);
        chk32("midrst_busy", 32'(busy), 32'd0);
        exp_q.delete();
        @(posedge clk); #1 rst_n = 1'b1;
        @(posedge clk); #1;
        send(rfc_key, rfc_nonce, 32'd1, acc1);
        wait_out(blk);
        chk32("postrst_w0", blk[31:0], 32'he4e7f110);
        @(posedge clk); #1;

        // Back-to-back blocks, counters 1 then 2.
        send(rfc_key, rfc_nonce, 32'd1, acc1);
        send(rfc_key, rfc_nonce, 32'd2, acc2);
        chk32("b2b_spacing", 32'(acc2 - acc1), 32'(STEPS4 + 3));
        wait_out(blk);
        chk32("b2b_second_w0", blk[31:0], model(rfc_key, rfc_nonce, 32'd2) >> 0 & 512'hffffffff);
        @(posedge clk); #1;

`ifdef CHACHA_XOR_EN
        // RFC 8439 2.4.2 first block, then decrypt the ciphertext back.
        pt_s = "Ladies and Gentlemen of the class of '99: If I could offer you only";
        pt = '0;
        for (int i = 0; i < 64 && i < pt_s.len(); i++) pt[8*i +: 8] = pt_s[i];
        data_in = pt;
        send(rfc_key, {32'h00000000, 32'h4a000000, 32'h00000000}, 32'd1, acc1);
        wait_out(ct);
        chk32("xor_ct_w0", ct[31:0], 32'h9a352e6e);
        chk32("xor_ct_w1", ct[63:32], 32'h80f96825);
        @(posedge clk); #1;
        data_in = ct;
        send(rfc_key, {32'h00000000, 32'h4a000000, 32'h00000000}, 32'd1, acc1);
        wait_out(blk);
        chk("xor_roundtrip", blk, pt);
        @(posedge clk); #1;
        data_in = '0;
`endif

        t = 0;
        while (exp_q.size() != 0 && t < BUDGET) begin t++; @(negedge clk); end
        if (exp_q.size() != 0) timeout("drain");
        repeat (2) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
